// File: rtl/ins_cache_dm.sv
// Direct-mapped instruction cache: combinational lookup, single-line refill FSM, one-cycle flush.
// Optional ICACHE_PERF_CNT_EN adds saturating hit/miss counters (ohit_cnt, omiss_cnt).
module ins_cache_dm #(
  parameter int ADDR_W = 32,
  parameter int LINES  = 16,
  parameter int WORDS  = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  ireq,
  input  logic [ADDR_W-1:0]     iaddr,
  input  logic                  iflush,
  output logic                  ohit,
  output logic [31:0]           oins,
  output logic                  ostall,
  output logic                  omem_req,
  output logic [ADDR_W-1:0]     omem_addr,
  input  logic                  imem_valid,
  input  logic [32*WORDS-1:0]   imem_in
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]           ohit_cnt,
  output logic [31:0]           omiss_cnt
`endif
);

  localparam int OFF   = $clog2(WORDS);
  localparam int IDX   = $clog2(LINES);
  localparam int TAG_W = ADDR_W - OFF - IDX - 2;

  typedef enum logic {IDLE, MISS} state_t;

  state_t                             state_q, state_n;
  logic [LINES-1:0][WORDS-1:0][31:0]  data_q;
  logic [LINES-1:0][TAG_W-1:0]        tag_q;
  logic [LINES-1:0]                   valid_q;
  logic [ADDR_W-1:0]                  miss_addr_q;

  logic [OFF-1:0]   word_sel;
  logic [IDX-1:0]   idx, fill_idx;
  logic [TAG_W-1:0] tag, fill_tag;
  logic             lookup_hit, miss_start, fill;
  logic             unused_ok;

  assign word_sel  = iaddr[OFF+1:2];
  assign idx       = iaddr[OFF+IDX+1:OFF+2];
  assign tag       = iaddr[ADDR_W-1:OFF+IDX+2];
  assign fill_idx  = miss_addr_q[OFF+IDX+1:OFF+2];
  assign fill_tag  = miss_addr_q[ADDR_W-1:OFF+IDX+2];
  assign unused_ok = ^iaddr[1:0];

  always_ff @(posedge clk) begin
    if (resetn) state_q <= IDLE;
    else        state_q <= state_n;
  end

  // Flush and reset dominate: a refill completing in the same cycle is dropped.
  always_comb begin
    state_n    = state_q;
    miss_start = 1'b0;
    fill       = 1'b0;
    lookup_hit = valid_q[idx] && (tag_q[idx] == tag);
    ohit       = ireq && (state_q == IDLE) && lookup_hit && !iflush && !resetn;
    oins       = ohit ? data_q[idx][word_sel] : 32'h0;
    ostall     = !resetn && ((state_q == MISS) || (ireq && !ohit));
    omem_req   = (state_q == MISS);
    omem_addr  = (state_q == MISS) ? miss_addr_q : '0;
    case (state_q)
      IDLE: if (ireq && !ohit && !iflush && !resetn) begin
        miss_start = 1'b1;
        state_n    = MISS;
      end
      MISS: if (iflush) begin
        state_n = IDLE;
      end else if (imem_valid) begin
        fill    = !resetn;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn)          miss_addr_q <= '0;
    else if (miss_start) miss_addr_q <= {iaddr[ADDR_W-1:OFF+2], {(OFF+2){1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (resetn || iflush) valid_q <= '0;
    else if (fill)        valid_q[fill_idx] <= 1'b1;
  end

  // Data and tag storage is never reset; valid_q gates every use.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[fill_idx] <= imem_in;
      tag_q[fill_idx]  <= fill_tag;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (resetn || iflush) begin
      ohit_cnt  <= '0;
      omiss_cnt <= '0;
    end else begin
      if (ohit && (ohit_cnt != 32'hFFFF_FFFF))        ohit_cnt  <= ohit_cnt + 32'd1;
      if (miss_start && (omiss_cnt != 32'hFFFF_FFFF)) omiss_cnt <= omiss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ins_cache_dm.sv
// Directed self-checking bench for ins_cache_dm (default 32-bit, 16 lines, 4 words).
module tb_ins_cache_dm;
  logic         clk = 1'b0;
  logic         resetn, ireq, iflush, imem_valid;
  logic [31:0]  iaddr;
  logic         ohit, ostall, omem_req;
  logic [31:0]  oins, omem_addr;
  logic [127:0] imem_in;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]  ohit_cnt, omiss_cnt;
`endif
  int cmp = 0;
  int err = 0;

  ins_cache_dm #(.ADDR_W(32), .LINES(16), .WORDS(4)) dut (
    .clk(clk), .resetn(resetn), .ireq(ireq), .iaddr(iaddr), .iflush(iflush),
    .ohit(ohit), .oins(oins), .ostall(ostall), .omem_req(omem_req),
    .omem_addr(omem_addr), .imem_valid(imem_valid), .imem_in(imem_in)
`ifdef ICACHE_PERF_CNT_EN
    , .ohit_cnt(ohit_cnt), .omiss_cnt(omiss_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    resetn = 1'b1; ireq = 1'b0; iflush = 1'b0; imem_valid = 1'b0;
    iaddr = '0; imem_in = '0;
    tick(); tick();
    resetn = 1'b0; #1;
    cmp++; if (ohit !== 1'b0)      begin err++; $display("FAIL reset_ohit got %0b want 0", ohit); end
    cmp++; if (ostall !== 1'b0)    begin err++; $display("FAIL reset_ostall got %0b want 0", ostall); end
    cmp++; if (omem_req !== 1'b0)  begin err++; $display("FAIL reset_mem_req got %0b want 0", omem_req); end
    cmp++; if (omem_addr !== 32'h0) begin err++; $display("FAIL reset_mem_addr got %h want 0", omem_addr); end
    cmp++; if (oins !== 32'h0)     begin err++; $display("FAIL reset_oins got %h want 0", oins); end
  endtask

  task automatic test_cold_miss();
    ireq = 1'b1; iaddr = 32'h7; #1;
    cmp++; if (ohit !== 1'b0)   begin err++; $display("FAIL cold_ohit got %0b want 0", ohit); end
    cmp++; if (ostall !== 1'b1) begin err++; $display("FAIL cold_ostall got %0b want 1", ostall); end
    tick();
    cmp++; if (omem_req !== 1'b1)   begin err++; $display("FAIL cold_mem_req got %0b want 1", omem_req); end
    cmp++; if (omem_addr !== 32'h0) begin err++; $display("FAIL cold_mem_addr got %h want 0", omem_addr); end
    tick(); tick();
    imem_in = {32'hDEADBEEF, 32'hABABABAB, 32'hCDCDCDCD, 32'hEFEFEFEF};
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0; #1;
    cmp++; if (ohit !== 1'b1)         begin err++; $display("FAIL cold_fill_ohit got %0b want 1", ohit); end
    cmp++; if (oins !== 32'hCDCDCDCD) begin err++; $display("FAIL cold_fill_oins got %h want cdcdcdcd", oins); end
    cmp++; if (ostall !== 1'b0)       begin err++; $display("FAIL cold_fill_ostall got %0b want 0", ostall); end
`ifdef ICACHE_PERF_CNT_EN
    cmp++; if (omiss_cnt !== 32'd1) begin err++; $display("FAIL cold_miss_cnt got %0d want 1", omiss_cnt); end
`endif
  endtask

  task automatic test_same_line();
    logic [31:0] exp [4];
    exp = '{32'hEFEFEFEF, 32'hCDCDCDCD, 32'hABABABAB, 32'hDEADBEEF};
    for (int i = 0; i < 4; i++) begin
      iaddr = 32'(i * 4); #1;
      cmp++; if (ohit !== 1'b1)   begin err++; $display("FAIL same_line_ohit[%0d] got %0b want 1", i, ohit); end
      cmp++; if (oins !== exp[i]) begin err++; $display("FAIL same_line_oins[%0d] got %h want %h", i, oins, exp[i]); end
      tick();
      cmp++; if (omem_req !== 1'b0) begin err++; $display("FAIL same_line_mem_req[%0d] got %0b want 0", i, omem_req); end
    end
  endtask

  task automatic test_conflict();
    iaddr = 32'h100; #1;
    cmp++; if (ohit !== 1'b0) begin err++; $display("FAIL conflict_ohit got %0b want 0", ohit); end
    tick();
    cmp++; if (omem_addr !== 32'h100) begin err++; $display("FAIL conflict_mem_addr got %h want 100", omem_addr); end
    imem_in = {4{32'h11111111}}; imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0; iaddr = 32'h104; #1;
    cmp++; if (oins !== 32'h11111111) begin err++; $display("FAIL conflict_oins got %h want 11111111", oins); end
    iaddr = 32'h0; #1;
    cmp++; if (ohit !== 1'b0) begin err++; $display("FAIL conflict_evict_ohit got %0b want 0", ohit); end
    tick();
    cmp++; if (omem_addr !== 32'h0) begin err++; $display("FAIL conflict_refetch_addr got %h want 0", omem_addr); end
    imem_in = {32'hDEADBEEF, 32'hABABABAB, 32'hCDCDCDCD, 32'hEFEFEFEF}; imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0; #1;
    cmp++; if (oins !== 32'hEFEFEFEF) begin err++; $display("FAIL conflict_refill_oins got %h want efefefef", oins); end
  endtask

  task automatic test_mid_miss();
    iaddr = 32'h40;
    tick();
    iaddr = 32'h80; #1;
    cmp++; if (omem_addr !== 32'h40) begin err++; $display("FAIL mid_miss_addr got %h want 40", omem_addr); end
    tick();
    cmp++; if (omem_addr !== 32'h40) begin err++; $display("FAIL mid_miss_addr_hold got %h want 40", omem_addr); end
    imem_in = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0}; imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0; iaddr = 32'h48; #1;
    cmp++; if (oins !== 32'hA2A2A2A2) begin err++; $display("FAIL mid_miss_hit40 got %h want a2a2a2a2", oins); end
    iaddr = 32'h80; #1;
    cmp++; if (ohit !== 1'b0)   begin err++; $display("FAIL mid_miss_80_ohit got %0b want 0", ohit); end
    cmp++; if (ostall !== 1'b1) begin err++; $display("FAIL mid_miss_80_stall got %0b want 1", ostall); end
    ireq = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    ireq = 1'b1; iaddr = 32'h0; #1;
    cmp++; if (ohit !== 1'b1) begin err++; $display("FAIL flush_pre_ohit got %0b want 1", ohit); end
    iflush = 1'b1; #1;
    cmp++; if (ohit !== 1'b0) begin err++; $display("FAIL flush_suppress_ohit got %0b want 0", ohit); end
    tick();
    iflush = 1'b0; #1;
    cmp++; if (omem_req !== 1'b0) begin err++; $display("FAIL flush_no_miss got %0b want 0", omem_req); end
    cmp++; if (ohit !== 1'b0)     begin err++; $display("FAIL flush_invalid_ohit got %0b want 0", ohit); end
    tick();
    cmp++; if (omem_req !== 1'b1) begin err++; $display("FAIL flush_miss_req got %0b want 1", omem_req); end
    iflush = 1'b1; imem_valid = 1'b1; imem_in = {4{32'h55555555}};
    tick();
    iflush = 1'b0; imem_valid = 1'b0; #1;
    cmp++; if (omem_req !== 1'b0) begin err++; $display("FAIL flush_abort_req got %0b want 0", omem_req); end
    cmp++; if (ohit !== 1'b0)     begin err++; $display("FAIL flush_abort_nofill got %0b want 0", ohit); end
    ireq = 1'b0; #1;
    cmp++; if (ostall !== 1'b0) begin err++; $display("FAIL flush_abort_idle got %0b want 0", ostall); end
  endtask

  task automatic test_reset_mid_miss();
    imem_in = {4{32'h77777777}}; imem_valid = 1'b1; iaddr = 32'h40;
    tick();
    imem_valid = 1'b0; ireq = 1'b1; #1;
    cmp++; if (ohit !== 1'b0) begin err++; $display("FAIL idle_valid_ignored got %0b want 0", ohit); end
    tick();
    cmp++; if (omem_req !== 1'b1) begin err++; $display("FAIL rst_miss_req got %0b want 1", omem_req); end
    resetn = 1'b1; ireq = 1'b0;
    tick();
    resetn = 1'b0; #1;
    cmp++; if (omem_req !== 1'b0) begin err++; $display("FAIL rst_miss_req_after got %0b want 0", omem_req); end
    cmp++; if (ostall !== 1'b0)   begin err++; $display("FAIL rst_miss_stall got %0b want 0", ostall); end
`ifdef ICACHE_PERF_CNT_EN
    cmp++; if (ohit_cnt !== 32'd0)  begin err++; $display("FAIL rst_hit_cnt got %0d want 0", ohit_cnt); end
    cmp++; if (omiss_cnt !== 32'd0) begin err++; $display("FAIL rst_miss_cnt got %0d want 0", omiss_cnt); end
`endif
    ireq = 1'b1; iaddr = 32'h0; #1;
    cmp++; if (ohit !== 1'b0) begin err++; $display("FAIL rst_lines_invalid got %0b want 0", ohit); end
    ireq = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_same_line();
    test_conflict();
    test_mid_miss();
    test_flush();
    test_reset_mid_miss();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
